demux_1_to_n_stream: RTL and testbench

- Registered 1-to-N stream demultiplexer; the distribution-side counterpart of the N-to-1 select mux.
- Takes one valid/ready input stream with a binary lane select and delivers each beat to exactly one of N output lanes.
- Each lane has a one-entry output register with independent backpressure.
- Sits between a shared producer and N per-lane consumers.

---
 rtl/demux_1_to_n_stream.sv | 131 +++++++++++++
 tb/tb_demux_1_to_n_stream.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1_to_n_stream.sv
// demux_1_to_n_stream
//
// Registered 1-to-N stream demultiplexer. One valid/ready input stream carries
// a binary lane select with every beat; each accepted beat is delivered to
// exactly one of N output lanes. Every lane owns a one-entry output register
// with its own backpressure, so a stalled consumer only ever blocks beats
// aimed at its own lane. Beats whose select is not a real lane are discarded
// and counted.
//
// Parameters:
//   N   number of output lanes (N >= 1)
//   m   select width, m >= ceil(log2(N)), m >= 1
//   W   data width per beat
//   CW  width of the saturating drop counter
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst_n       asynchronous active-low reset
//   flush       synchronous clear of all lane registers (beats accepted are lost)
//   in_valid    input beat valid
//   in_ready    input beat accepted this cycle when high together with in_valid
//   in_data     input beat payload
//   in_select   destination lane index, sampled with in_data
//   out_valid   per-lane beat valid, bit i = lane i
//   out_ready   per-lane consumer ready
//   out_data    lane i payload at bits [i*W +: W]
//   drop_pulse  one-cycle pulse: an out-of-range beat was discarded
//   drop_cnt    saturating count of discarded beats
//   busy        OR of out_valid

module demux_1_to_n_stream #(
    parameter int N  = 9,
    parameter int m  = 4,
    parameter int W  = 8,
    parameter int CW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic [m-1:0]     in_select,
    output logic [N-1:0]     out_valid,
    input  logic [N-1:0]     out_ready,
    output logic [N*W-1:0]   out_data,
    output logic             drop_pulse,
    output logic [CW-1:0]    drop_cnt,
    output logic             busy
);

    logic [m-1:0]          sel;
    logic                  sel_in_range;
    logic [N-1:0]          lane_hit;
    logic                  lane_free;
    logic                  accept;
    logic [N-1:0]          load;
    logic [N-1:0][W-1:0]   lane_data;

    // With a single lane there is nothing to choose, so the select input is
    // ignored entirely and every beat goes to lane 0.
    assign sel          = (N == 1) ? '0 : in_select;
    assign sel_in_range = (32'(sel) < 32'(N));

    // Decode the select into a one-hot lane hit and find out whether the
    // addressed lane can take a beat this cycle. A lane can take a beat when
    // it is empty or when its consumer is draining it right now, which gives
    // full throughput into a single lane. in_valid is deliberately kept out
    // of this path so in_ready never depends on it.
    always_comb begin
        lane_hit  = '0;
        lane_free = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (32'(sel) == 32'(i)) begin
                lane_hit[i] = 1'b1;
                lane_free   = !out_valid[i] || out_ready[i];
            end
        end
        if (flush) begin
            in_ready = 1'b0;
        end else if (!sel_in_range) begin
            in_ready = 1'b1;
        end else begin
            in_ready = lane_free;
        end
    end

    assign accept = in_valid && in_ready;
    assign load   = lane_hit & {N{accept}};

    // Lane registers. Flush wins over everything; otherwise a lane being
    // loaded takes the new beat (even while it is being drained, which is the
    // back-to-back case), and a lane drained without reload goes empty. Data
    // is left in place on drain since it is only meaningful while valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= '0;
            lane_data <= '0;
        end else if (flush) begin
            out_valid <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (load[i]) begin
                    out_valid[i] <= 1'b1;
                    lane_data[i] <= in_data;
                end else if (out_ready[i]) begin
                    out_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Out-of-range beats are accepted so the producer never stalls on them,
    // then thrown away. The counter sticks at all-ones rather than wrapping so
    // a large count is never mistaken for a small one. Flush leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_pulse <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            drop_pulse <= accept && !sel_in_range;
            if (accept && !sel_in_range && (drop_cnt != {CW{1'b1}})) begin
                drop_cnt <= drop_cnt + CW'(1);
            end
        end
    end

    assign out_data = lane_data;
    assign busy     = |out_valid;

endmodule

// File: tb/tb_demux_1_to_n_stream.sv
// tb_demux_1_to_n_stream
//
// Self-checking bench for demux_1_to_n_stream. The main instance (N=9, CW=8)
// is driven together with a twin whose drop counter is only 2 bits wide, so
// counter saturation is visible on the same stimulus. A third instance with
// a single lane covers the N=1 case. A queue-per-lane reference model tracks
// what every lane should be holding.

module tb_demux_1_to_n_stream;

    localparam int N = 9;
    localparam int M = 4;
    localparam int W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic [M-1:0]     in_select;
    logic [N-1:0]     out_valid;
    logic [N-1:0]     out_ready;
    logic [N*W-1:0]   out_data;
    logic             drop_pulse;
    logic [7:0]       drop_cnt;
    logic             busy;

    logic             s_in_ready;
    logic [N-1:0]     s_out_valid;
    logic [N*W-1:0]   s_out_data;
    logic             s_drop_pulse;
    logic [1:0]       s_drop_cnt;
    logic             s_busy;

    logic             v1;
    logic             ready1;
    logic [W-1:0]     d1;
    logic [0:0]       sel1;
    logic [0:0]       ov1;
    logic [0:0]       rdy1;
    logic [W-1:0]     od1;
    logic             dp1;
    logic [7:0]       dc1;
    logic             busy1;

    int checks   = 0;
    int failures = 0;

    // Reference model: each lane is a FIFO of capacity one, plus a running
    // total of discarded beats.
    logic [W-1:0] mq [N][$];
    int           mdrops;
    bit           mpulse;

    // Drive a free-running clock; all stimulus changes 1 time unit after a
    // rising edge, well away from the next one.
    always #5 clk = ~clk;

    demux_1_to_n_stream #(.N(N), .m(M), .W(W), .CW(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_select(in_select),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .drop_pulse(drop_pulse), .drop_cnt(drop_cnt), .busy(busy)
    );

    demux_1_to_n_stream #(.N(N), .m(M), .W(W), .CW(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_select(in_select),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .drop_pulse(s_drop_pulse), .drop_cnt(s_drop_cnt), .busy(s_busy)
    );

    demux_1_to_n_stream #(.N(1), .m(1), .W(W), .CW(8)) dut_one (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(v1), .in_ready(ready1), .in_data(d1), .in_select(sel1),
        .out_valid(ov1), .out_ready(rdy1), .out_data(od1),
        .drop_pulse(dp1), .drop_cnt(dc1), .busy(busy1)
    );

    typedef struct {
        int           sel;
        logic [W-1:0] data;
        logic [N-1:0] exp_valid;
        logic         exp_pulse;
        int           exp_cnt;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic bit model_ready(input int sel, input logic [N-1:0] rdy, input bit fl);
        if (fl) return 1'b0;
        if (sel >= N) return 1'b1;
        return (mq[sel].size() == 0) || rdy[sel];
    endfunction

    // Advance the model by one clock edge with the inputs that were applied.
    task automatic model_step(input bit v, input int sel, input logic [W-1:0] d,
                              input logic [N-1:0] rdy, input bit fl);
        bit acc;
        acc    = v && model_ready(sel, rdy, fl);
        mpulse = acc && (sel >= N);
        if (mpulse) mdrops++;
        for (int i = 0; i < N; i++) begin
            if (fl) begin
                mq[i].delete();
            end else begin
                if (mq[i].size() > 0 && rdy[i]) void'(mq[i].pop_front());
                if (acc && sel == i) mq[i].push_back(d);
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) mq[i].delete();
        mdrops = 0;
        mpulse = 0;
    endtask

    // Compare every registered output of both N=9 instances with the model.
    task automatic checkOutput(input string tag);
        logic [N-1:0] ev;
        ev = '0;
        for (int i = 0; i < N; i++) begin
            ev[i] = (mq[i].size() > 0);
            if (ev[i]) check($sformatf("%s lane%0d data", tag, i), out_data[i*W +: W], mq[i][0]);
        end
        check({tag, " out_valid"}, out_valid, ev);
        check({tag, " busy"}, busy, |ev);
        check({tag, " drop_pulse"}, drop_pulse, mpulse);
        check({tag, " drop_cnt"}, drop_cnt, (mdrops > 255) ? 255 : mdrops);
        check({tag, " sat drop_cnt"}, s_drop_cnt, (mdrops > 3) ? 3 : mdrops);
    endtask

    // Apply one cycle of stimulus, check the combinational handshake before
    // the edge and the registered outputs just after it.
    task automatic applyStimulus(input string tag, input bit v, input int sel, input logic [W-1:0] d,
                                 input logic [N-1:0] rdy, input bit fl);
        in_valid  = v;
        in_select = sel[M-1:0];
        in_data   = d;
        out_ready = rdy;
        flush     = fl;
        #1;
        check({tag, " in_ready"}, in_ready, model_ready(sel, rdy, fl));
        @(posedge clk);
        model_step(v, sel, d, rdy, fl);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        logic [N-1:0] all1;
        logic [N-1:0] rdy;
        all1 = '1;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_select = '0; out_ready = all1;
        v1 = 1'b0; d1 = '0; sel1 = '0; rdy1 = 1'b1;
        model_reset();
        #2;
        check("reset out_valid", out_valid, 0);
        check("reset out_data", out_data, 0);
        check("reset drop_cnt", drop_cnt, 0);
        check("reset drop_pulse", drop_pulse, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Routing table: one beat, then an idle cycle so the lane drains.
        vecs[0] = '{3,  8'hA5, 9'h008, 1'b0, 0};
        vecs[1] = '{0,  8'h3C, 9'h001, 1'b0, 0};
        vecs[2] = '{8,  8'h7E, 9'h100, 1'b0, 0};
        vecs[3] = '{9,  8'h11, 9'h000, 1'b1, 1};
        vecs[4] = '{12, 8'h22, 9'h000, 1'b1, 2};
        vecs[5] = '{15, 8'h33, 9'h000, 1'b1, 3};
        vecs[6] = '{5,  8'h5A, 9'h020, 1'b0, 3};
        for (int k = 0; k < 7; k++) begin
            applyStimulus($sformatf("vec%0d", k), 1'b1, vecs[k].sel, vecs[k].data, all1, 1'b0);
            check($sformatf("vec%0d tbl out_valid", k), out_valid, vecs[k].exp_valid);
            check($sformatf("vec%0d tbl drop_pulse", k), drop_pulse, vecs[k].exp_pulse);
            check($sformatf("vec%0d tbl drop_cnt", k), drop_cnt, vecs[k].exp_cnt);
            if (vecs[k].sel < N)
                check($sformatf("vec%0d tbl data", k), out_data[vecs[k].sel*W +: W], vecs[k].data);
            applyStimulus($sformatf("idle%0d", k), 1'b0, 0, 8'h00, all1, 1'b0);
        end

        // Two more drops: the 2-bit counter must stick at 3.
        applyStimulus("drop4", 1'b1, 10, 8'h44, all1, 1'b0);
        applyStimulus("drop5", 1'b1, 11, 8'h55, all1, 1'b0);
        check("sat hold", s_drop_cnt, 2'd3);
        check("cnt five", drop_cnt, 8'd5);

        // Backpressure on lane 5.
        rdy = all1; rdy[5] = 1'b0;
        applyStimulus("bp1", 1'b1, 5, 8'h11, rdy, 1'b0);
        for (int k = 0; k < 2; k++) begin
            applyStimulus("bp2", 1'b1, 5, 8'h22, rdy, 1'b0);
            check("bp held data", out_data[5*W +: W], 8'h11);
            check("bp held valid", out_valid[5], 1'b1);
        end
        in_valid = 1'b1; #1;
        check("bp blocked in_ready", in_ready, 1'b0);
        applyStimulus("bp3", 1'b1, 5, 8'h22, all1, 1'b0);
        check("bp reload data", out_data[5*W +: W], 8'h22);
        applyStimulus("bp4", 1'b0, 0, 8'h00, all1, 1'b0);

        // Lane 2 stalled full; stream to lanes 0 and 7 at full rate.
        rdy = all1; rdy[2] = 1'b0;
        applyStimulus("ind0", 1'b1, 2, 8'h99, rdy, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            applyStimulus($sformatf("ind%0d", k), 1'b1, (k % 2 == 1) ? 0 : 7, k[7:0], rdy, 1'b0);
            check($sformatf("ind%0d accepted", k), out_data[((k % 2 == 1) ? 0 : 7)*W +: W], k[7:0]);
        end
        check("ind lane2 data", out_data[2*W +: W], 8'h99);

        // Lanes 1, 4, 8 (and 2) full and stalled, then flush.
        rdy = all1; rdy[1] = 1'b0; rdy[2] = 1'b0; rdy[4] = 1'b0; rdy[8] = 1'b0;
        applyStimulus("fl1", 1'b1, 1, 8'hB1, rdy, 1'b0);
        applyStimulus("fl4", 1'b1, 4, 8'hB4, rdy, 1'b0);
        applyStimulus("fl8", 1'b1, 8, 8'hB8, rdy, 1'b0);
        check("fl pre valid", out_valid, 9'h116);
        applyStimulus("flush", 1'b1, 0, 8'hCC, rdy, 1'b1);
        check("flush out_valid", out_valid, 0);
        check("flush keeps cnt", drop_cnt, 8'd5);
        in_valid = 1'b1; flush = 1'b1; in_select = 4'd12; #1;
        check("flush in_ready", in_ready, 1'b0);
        flush = 1'b0;

        // Asynchronous reset while a lane is full and a drop pulse is high.
        rdy = all1; rdy[6] = 1'b0;
        applyStimulus("ar1", 1'b1, 6, 8'h66, rdy, 1'b0);
        applyStimulus("ar2", 1'b1, 10, 8'h77, rdy, 1'b0);
        check("ar pulse", drop_pulse, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("ar out_valid", out_valid, 0);
        check("ar out_data", out_data, 0);
        check("ar drop_pulse", drop_pulse, 0);
        check("ar drop_cnt", drop_cnt, 0);
        check("ar busy", busy, 0);
        rst_n = 1'b1;

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            applyStimulus("rnd", ($urandom % 4) != 0, int'($urandom_range(0, 15)), 8'($urandom),
                          N'($urandom), ($urandom % 25) == 0);
        end
        applyStimulus("rnd end", 1'b0, 0, 8'h00, all1, 1'b0);

        // Single-lane instance: select is ignored, nothing is ever dropped.
        in_valid = 1'b0;
        v1 = 1'b1; sel1 = 1'b1; d1 = 8'h5C; rdy1 = 1'b1; #1;
        check("n1 ready", ready1, 1'b1);
        @(posedge clk); #1;
        check("n1 valid", ov1, 1'b1);
        check("n1 data", od1, 8'h5C);
        check("n1 drop_cnt", dc1, 0);
        check("n1 drop_pulse", dp1, 0);
        sel1 = 1'b0; d1 = 8'hC3;
        @(posedge clk); #1;
        check("n1 reload data", od1, 8'hC3);
        rdy1 = 1'b0; sel1 = 1'b1; #1;
        check("n1 stalled ready", ready1, 1'b0);
        @(posedge clk); #1;
        check("n1 hold data", od1, 8'hC3);
        check("n1 final drop_cnt", dc1, 0);
        v1 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
